// File: rtl/timer_switch_pkg.sv
// Shared defaults for the staircase-light timer switch.
package timer_switch_pkg;

    localparam int unsigned ON_TIME_DEF = 20;

    function automatic int unsigned cnt_width(input int unsigned on_time);
        return $clog2(on_time + 1);
    endfunction

endpackage

// File: rtl/timer_switch_counter.sv
// Loadable down-counter that saturates at zero; busy while nonzero.
module timer_switch_counter
    import timer_switch_pkg::*;
#(
    parameter int unsigned ON_TIME = ON_TIME_DEF,
    parameter int unsigned CNT_W   = cnt_width(ON_TIME)
) (
    input  logic clock_1Hz,
    input  logic reset,
    input  logic load,
    output logic busy
);

    logic [CNT_W-1:0] cnt;

    // Load wins over the decrement so a press on the last on-cycle never drops the light.
    always_ff @(posedge clock_1Hz) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(ON_TIME);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/timer_switch_top.sv
// Staircase-light timer: a button rising edge lights the lamp for ON_TIME ticks.
module timer_switch_top
    import timer_switch_pkg::*;
#(
    parameter int unsigned ON_TIME = ON_TIME_DEF
) (
    input  logic clock_1Hz,
    input  logic reset,
    input  logic btn_ext,
    output logic light
);

    localparam int unsigned CNT_W = cnt_width(ON_TIME);

    logic btn_prev;
    logic press;

    // Reset value of 1 keeps a button held through reset from triggering.
    always_ff @(posedge clock_1Hz) begin
        if (!reset) begin
            btn_prev <= 1'b1;
        end else begin
            btn_prev <= btn_ext;
        end
    end

    assign press = btn_ext & ~btn_prev;

    timer_switch_counter #(
        .ON_TIME (ON_TIME),
        .CNT_W   (CNT_W)
    ) u_counter (
        .clock_1Hz (clock_1Hz),
        .reset     (reset),
        .load      (press),
        .busy      (light)
    );

endmodule

// File: tb/tb_timer_switch_top.sv
// Self-checking bench for timer_switch_top with the default 20-tick on-time.
module tb_timer_switch_top;

    logic clock_1Hz = 1'b0;
    logic reset     = 1'b0;
    logic btn_ext   = 1'b0;
    logic light;

    timer_switch_top #(
        .ON_TIME (20)
    ) dut (
        .clock_1Hz (clock_1Hz),
        .reset     (reset),
        .btn_ext   (btn_ext),
        .light     (light)
    );

    always #5 clock_1Hz = ~clock_1Hz;

    typedef struct {
        logic        exp;
        string       name;
        int unsigned idx;
    } sb_item_t;

    typedef struct {
        logic        rst_n;
        logic        btn;
        int unsigned cycles;
        logic        exp;
        string       name;
    } vec_t;

    sb_item_t    exp_q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned seq_idx = 0;

    // Expectations describe light after the next rising edge; checked 1 time unit past it.
    always @(posedge clock_1Hz) begin
        #1;
        if (exp_q.size() > 0) begin
            sb_item_t it;
            it = exp_q.pop_front();
            checks++;
            if (light !== it.exp) begin
                errors++;
                $display("FAIL %s[%0d] light=%b expected=%b at %0t",
                         it.name, it.idx, light, it.exp, $time);
            end
        end
    end

    task automatic step(input logic r, input logic b, input logic e, input string nm);
        sb_item_t it;
        @(negedge clock_1Hz);
        reset   = r;
        btn_ext = b;
        it.exp  = e;
        it.name = nm;
        it.idx  = seq_idx;
        seq_idx++;
        exp_q.push_back(it);
    endtask

    task automatic run(input logic r, input logic b, input int unsigned n,
                       input logic e, input string nm);
        seq_idx = 0;
        for (int unsigned i = 0; i < n; i++) begin
            step(r, b, e, nm);
        end
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1'b0, 1'b0,  2, 1'b0, "reset"};
        vecs[1] = '{1'b1, 1'b0,  5, 1'b0, "idle"};
        vecs[2] = '{1'b1, 1'b1,  4, 1'b1, "press_held"};
        vecs[3] = '{1'b1, 1'b0, 16, 1'b1, "press_on"};
        vecs[4] = '{1'b1, 1'b0,  3, 1'b0, "press_expired"};
        vecs[5] = '{1'b1, 1'b1, 20, 1'b1, "hold_on"};
        vecs[6] = '{1'b1, 1'b1,  5, 1'b0, "hold_expired"};
        vecs[7] = '{1'b1, 1'b0,  1, 1'b0, "hold_release"};
        vecs[8] = '{1'b1, 1'b1, 20, 1'b1, "repress_on"};
        vecs[9] = '{1'b1, 1'b0,  2, 1'b0, "repress_off"};

        for (int unsigned v = 0; v < 10; v++) begin
            run(vecs[v].rst_n, vecs[v].btn, vecs[v].cycles, vecs[v].exp, vecs[v].name);
        end

        // Retrigger ten ticks after the first press extends to 20 ticks after the second.
        run(1'b1, 1'b1,  1, 1'b1, "retrig_p1");
        run(1'b1, 1'b0,  9, 1'b1, "retrig_gap");
        run(1'b1, 1'b1,  1, 1'b1, "retrig_p2");
        run(1'b1, 1'b0, 19, 1'b1, "retrig_on");
        run(1'b1, 1'b0,  2, 1'b0, "retrig_off");

        // Second press lands on the edge that would have cleared the last on-cycle.
        run(1'b1, 1'b1,  1, 1'b1, "edge_p1");
        run(1'b1, 1'b0, 19, 1'b1, "edge_on1");
        run(1'b1, 1'b1,  1, 1'b1, "edge_p2");
        run(1'b1, 1'b0, 19, 1'b1, "edge_on2");
        run(1'b1, 1'b0,  2, 1'b0, "edge_off");

        // Reset mid-run with the button still held.
        run(1'b1, 1'b1,  5, 1'b1, "mid_on");
        run(1'b0, 1'b1,  1, 1'b0, "mid_reset");
        run(1'b1, 1'b1,  3, 1'b0, "held_after_reset");
        run(1'b1, 1'b0,  1, 1'b0, "released");
        run(1'b1, 1'b1,  1, 1'b1, "post_reset_press");
        run(1'b1, 1'b0, 19, 1'b1, "post_reset_on");
        run(1'b1, 1'b0,  3, 1'b0, "post_reset_off");

        repeat (3) @(posedge clock_1Hz);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog time=%0t expected completion earlier", $time);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
